// File: rtl/ltc2324_acq_pkg.sv
// Shared types and constants for the LTC2324-16 acquisition controller.
package ltc2324_acq_pkg;

    localparam int unsigned SampleW = 16;
    localparam int unsigned NumCh   = 4;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } acq_state_e;

    // An empty channel mask would produce sets with no beats; fall back to ch1 only.
    function automatic logic [NumCh-1:0] norm_mask(input logic [NumCh-1:0] mask);
        return (mask == '0) ? {{(NumCh-1){1'b0}}, 1'b1} : mask;
    endfunction

endpackage

// File: rtl/ltc2324_ch_serializer.sv
// Snapshots one ADC sample set and emits one AXI4-Stream beat per enabled channel,
// lowest channel index first.
module ltc2324_ch_serializer
    import ltc2324_acq_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load,
    input  logic                            load_last,
    input  logic [NumCh-1:0]                load_mask,
    input  logic [NumCh-1:0][SampleW-1:0]   load_data,
    output logic [SampleW-1:0]              m_axis_tdata,
    output ch_idx_t                         m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            empty,
    output logic                            final_xfer
);

    logic [NumCh-1:0][SampleW-1:0] data_q;
    logic [NumCh-1:0]              pend_q, pend_d;
    logic                          last_q;

    ch_idx_t          cur_ch;
    logic [NumCh-1:0] cur_bit;
    logic [NumCh-1:0] rest;
    logic             final_beat;
    logic             xfer;

    // Pick the lowest pending channel; descending scan leaves the lowest index last.
    always_comb begin
        cur_ch  = '0;
        cur_bit = '0;
        for (int i = NumCh - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                cur_ch  = ch_idx_t'(i);
                cur_bit = '0;
                cur_bit[i] = 1'b1;
            end
        end
    end

    // Beat outputs and pending-set bookkeeping.
    always_comb begin
        rest          = pend_q & ~cur_bit;
        final_beat    = (rest == '0);
        m_axis_tvalid = |pend_q;
        m_axis_tdata  = data_q[cur_ch];
        m_axis_tuser  = cur_ch;
        m_axis_tlast  = m_axis_tvalid & last_q & final_beat;
        xfer          = m_axis_tvalid & m_axis_tready;
        final_xfer    = xfer & final_beat;
        empty         = ~m_axis_tvalid;
        pend_d        = pend_q;
        if (load) begin
            pend_d = load_mask;
        end else if (xfer) begin
            pend_d = rest;
        end
    end

    // Snapshot and pending-channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            pend_q <= '0;
            last_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (load) begin
                data_q <= load_data;
                last_q <= load_last;
            end
        end
    end

endmodule

// File: rtl/ltc2324_acq_ctrl.sv
// LTC2324-16 acquisition controller: gates the driver sample enable, decimates sample
// sets, counts kept sets into frames and hands each set to the channel serializer.
module ltc2324_acq_ctrl
    import ltc2324_acq_pkg::*;
#(
    parameter int unsigned FRAME_W = 16,
    parameter int unsigned DECIM_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [FRAME_W-1:0]  cfg_frame_len,
    input  logic [DECIM_W-1:0]  cfg_decim,
    input  logic [NumCh-1:0]    cfg_ch_mask,
    input  logic                cfg_continuous,
    output logic                adc_sample_en,
    input  logic                adc_valid,
    input  logic [SampleW-1:0]  adc_ch1,
    input  logic [SampleW-1:0]  adc_ch2,
    input  logic [SampleW-1:0]  adc_ch3,
    input  logic [SampleW-1:0]  adc_ch4,
    output logic [SampleW-1:0]  m_axis_tdata,
    output logic [1:0]          m_axis_tuser,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun
);

    acq_state_e         state_q, state_d;
    logic               valid_q;
    logic [DECIM_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [FRAME_W-1:0] set_cnt_q, set_cnt_d;
    logic [FRAME_W-1:0] set_cnt_inc;
    logic [FRAME_W-1:0] frame_len_q;
    logic [DECIM_W-1:0] decim_q;
    logic [NumCh-1:0]   mask_q;
    logic               cont_q;
    logic               stop_pend_q, stop_pend_d;
    logic               overrun_q, overrun_d;
    logic               frame_done_q;

    logic    cfg_load;
    logic    set_evt;
    logic    keep;
    logic    frame_end;
    logic    ser_load;
    logic    ser_empty;
    logic    ser_final_xfer;
    ch_idx_t ser_tuser;

    // Rising edge of the driver valid level marks one sample set, however long valid stays high.
    always_comb begin
        set_evt     = adc_valid & ~valid_q;
        keep        = set_evt & (dec_cnt_q == '0);
        set_cnt_inc = set_cnt_q + FRAME_W'(1);
        frame_end   = (state_q == StRun) & keep & ser_empty & (set_cnt_inc == frame_len_q);
    end

    // Next-state logic: sequencing, decimation, frame counting and overrun detection.
    always_comb begin
        state_d     = state_q;
        dec_cnt_d   = dec_cnt_q;
        set_cnt_d   = set_cnt_q;
        stop_pend_d = stop_pend_q;
        overrun_d   = overrun_q;
        cfg_load    = 1'b0;
        ser_load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    cfg_load    = 1'b1;
                    dec_cnt_d   = '0;
                    set_cnt_d   = '0;
                    stop_pend_d = 1'b0;
                    overrun_d   = 1'b0;
                    state_d     = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (set_evt) begin
                    dec_cnt_d = (dec_cnt_q == decim_q) ? '0 : dec_cnt_q + DECIM_W'(1);
                    if (keep) begin
                        // A set arriving on the final beat's handshake still finds the
                        // serializer occupied and is dropped.
                        if (ser_empty) begin
                            ser_load = 1'b1;
                            if (frame_end) begin
                                set_cnt_d = '0;
                                if (!cont_q || stop_pend_q || stop) begin
                                    state_d = StDrain;
                                end
                            end else begin
                                set_cnt_d = set_cnt_inc;
                            end
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            StDrain: begin
                // Leave on the final beat's handshake so busy drops with frame_done rising.
                if (ser_empty || ser_final_xfer) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters and latched configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            valid_q      <= 1'b0;
            dec_cnt_q    <= '0;
            set_cnt_q    <= '0;
            frame_len_q  <= FRAME_W'(1);
            decim_q      <= '0;
            mask_q       <= {{(NumCh-1){1'b0}}, 1'b1};
            cont_q       <= 1'b0;
            stop_pend_q  <= 1'b0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= adc_valid;
            dec_cnt_q    <= dec_cnt_d;
            set_cnt_q    <= set_cnt_d;
            stop_pend_q  <= stop_pend_d;
            overrun_q    <= overrun_d;
            frame_done_q <= m_axis_tvalid & m_axis_tready & m_axis_tlast;
            if (cfg_load) begin
                frame_len_q <= (cfg_frame_len == '0) ? FRAME_W'(1) : cfg_frame_len;
                decim_q     <= cfg_decim;
                mask_q      <= norm_mask(cfg_ch_mask);
                cont_q      <= cfg_continuous;
            end
        end
    end

    ltc2324_ch_serializer u_ser (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (ser_load),
        .load_last     (frame_end),
        .load_mask     (mask_q),
        .load_data     ({adc_ch4, adc_ch3, adc_ch2, adc_ch1}),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (ser_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .empty         (ser_empty),
        .final_xfer    (ser_final_xfer)
    );

    // Status outputs decoded from registered state.
    always_comb begin
        m_axis_tuser  = ser_tuser;
        adc_sample_en = (state_q == StRun);
        busy          = (state_q != StIdle);
        frame_done    = frame_done_q;
        overrun       = overrun_q;
    end

endmodule

// File: tb/tb_ltc2324_acq_ctrl.sv
// Directed bench for ltc2324_acq_ctrl: drives a simple ADC driver model and checks beats,
// frame markers, busy/enable sequencing, overrun and reset behaviour.
module tb_ltc2324_acq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop;
    logic [15:0] cfg_frame_len;
    logic [7:0]  cfg_decim;
    logic [3:0]  cfg_ch_mask;
    logic        cfg_continuous;
    logic        adc_sample_en;
    logic        adc_valid;
    logic [15:0] adc_ch1, adc_ch2, adc_ch3, adc_ch4;
    logic [15:0] m_axis_tdata;
    logic [1:0]  m_axis_tuser;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic        busy, frame_done, overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    int fd_start;
    int q_start;

    // Beat packed as {tlast, tuser, tdata}.
    logic [18:0] got_q[$];
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    ltc2324_acq_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .cfg_frame_len  (cfg_frame_len),
        .cfg_decim      (cfg_decim),
        .cfg_ch_mask    (cfg_ch_mask),
        .cfg_continuous (cfg_continuous),
        .adc_sample_en  (adc_sample_en),
        .adc_valid      (adc_valid),
        .adc_ch1        (adc_ch1),
        .adc_ch2        (adc_ch2),
        .adc_ch3        (adc_ch3),
        .adc_ch4        (adc_ch4),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .busy           (busy),
        .frame_done     (frame_done),
        .overrun        (overrun)
    );

    // Inputs change just after posedge, so negedge sees what the next edge will sample.
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready)
            got_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
        if (rst_n && frame_done)
            fd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_test();
        exp_q.delete();
        q_start  = got_q.size();
        fd_start = fd_cnt;
    endtask

    task automatic do_start(input logic [15:0] fl, input logic [7:0] dc, input logic [3:0] mk,
                            input logic cont);
        cfg_frame_len  = fl;
        cfg_decim      = dc;
        cfg_ch_mask    = mk;
        cfg_continuous = cont;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Scramble config to prove it was latched.
        cfg_frame_len  = 16'hffff;
        cfg_decim      = 8'hff;
        cfg_ch_mask    = ~mk;
        cfg_continuous = ~cont;
    endtask

    // One driver sample set: valid high 4 cycles, then 8 idle cycles.
    task automatic send_set(input logic [15:0] base);
        adc_ch1   = base;
        adc_ch2   = base + 16'd1;
        adc_ch3   = base + 16'd2;
        adc_ch4   = base + 16'd3;
        adc_valid = 1'b1;
        repeat (4) tick();
        adc_valid = 1'b0;
        repeat (8) tick();
    endtask

    task automatic push_set(input logic [15:0] base, input logic [3:0] mask, input logic last);
        logic [3:0] m;
        int         top;
        m   = (mask == 4'd0) ? 4'b0001 : mask;
        top = 0;
        for (int i = 0; i < 4; i++) if (m[i]) top = i;
        for (int i = 0; i < 4; i++)
            if (m[i]) exp_q.push_back({(last && i == top), 2'(i), base + 16'(i)});
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && busy; i++) tick();
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_beats(input string tag);
        logic [18:0] g;
        check_eq({tag, "_nbeats"}, 32'(got_q.size() - q_start), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (q_start + i < got_q.size()) ? got_q[q_start + i] : 19'h7ffff;
            check_eq($sformatf("%s_beat%0d", tag, i), 32'(g), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0;
        cfg_frame_len = '0; cfg_decim = '0; cfg_ch_mask = '0; cfg_continuous = 1'b0;
        adc_valid = 1'b0;
        adc_ch1 = '0; adc_ch2 = '0; adc_ch3 = '0; adc_ch4 = '0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        check_eq("reset_outs",
                 {adc_sample_en, m_axis_tvalid, m_axis_tlast, busy, frame_done, overrun,
                  m_axis_tuser, m_axis_tdata}, '0);
        rst_n = 1'b1;
        tick();

        // Four channels, two sets per frame, one-shot; third set must be ignored.
        begin_test();
        do_start(16'd2, 8'd0, 4'b1111, 1'b0);
        check_eq("t1_busy_rise", 32'(busy), 32'd1);
        check_eq("t1_en_rise", 32'(adc_sample_en), 32'd1);
        send_set(16'h1000);
        send_set(16'h2000);
        check_eq("t1_en_fall", 32'(adc_sample_en), 32'd0);
        send_set(16'h3000);
        wait_idle("t1");
        push_set(16'h1000, 4'b1111, 1'b0);
        push_set(16'h2000, 4'b1111, 1'b1);
        check_beats("t1");
        check_eq("t1_frame_done", 32'(fd_cnt - fd_start), 32'd1);
        check_eq("t1_overrun", 32'(overrun), 32'd0);

        // Decimate by 3: sets 1, 4, 7 kept, channels 1 and 3 only.
        begin_test();
        do_start(16'd3, 8'd2, 4'b0101, 1'b0);
        for (int s = 1; s <= 9; s++) send_set(16'(s) << 8);
        wait_idle("t2");
        push_set(16'h0100, 4'b0101, 1'b0);
        push_set(16'h0400, 4'b0101, 1'b0);
        push_set(16'h0700, 4'b0101, 1'b1);
        check_beats("t2");
        check_eq("t2_frame_done", 32'(fd_cnt - fd_start), 32'd1);

        // Mask 0 means ch1 only; frame length 0 means one set per frame.
        begin_test();
        do_start(16'd0, 8'd0, 4'b0000, 1'b0);
        send_set(16'h4a00);
        send_set(16'h4b00);
        wait_idle("t3");
        push_set(16'h4a00, 4'b0001, 1'b1);
        check_beats("t3");

        // Backpressure: first set held intact, stalled sets dropped and not counted.
        begin_test();
        m_axis_tready = 1'b0;
        do_start(16'd2, 8'd0, 4'b0011, 1'b0);
        send_set(16'h5000);
        for (int s = 1; s <= 9; s++) send_set(16'h5000 + (16'(s) << 4));
        check_eq("t4_overrun", 32'(overrun), 32'd1);
        check_eq("t4_held", {15'd0, m_axis_tvalid, m_axis_tuser, m_axis_tdata},
                 {15'd0, 1'b1, 2'd0, 16'h5000});
        m_axis_tready = 1'b1;
        repeat (4) tick();
        check_eq("t4_busy_mid", 32'(busy), 32'd1);
        send_set(16'h6000);
        wait_idle("t4");
        push_set(16'h5000, 4'b0011, 1'b0);
        push_set(16'h6000, 4'b0011, 1'b1);
        check_beats("t4");
        check_eq("t4_overrun_sticky", 32'(overrun), 32'd1);

        // Continuous frames of 4, stop during frame 2 ends after 8 sets.
        begin_test();
        do_start(16'd4, 8'd0, 4'b0001, 1'b1);
        for (int s = 1; s <= 5; s++) send_set(16'h7000 + (16'(s) << 4));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("t5_en_after_stop", 32'(adc_sample_en), 32'd1);
        for (int s = 6; s <= 10; s++) send_set(16'h7000 + (16'(s) << 4));
        check_eq("t5_en_fall", 32'(adc_sample_en), 32'd0);
        wait_idle("t5");
        for (int s = 1; s <= 8; s++) push_set(16'h7000 + (16'(s) << 4), 4'b0001, (s % 4) == 0);
        check_beats("t5");
        check_eq("t5_frame_done", 32'(fd_cnt - fd_start), 32'd2);

        // Reset during a stall clears everything; next frame is clean.
        m_axis_tready = 1'b0;
        do_start(16'd2, 8'd0, 4'b1111, 1'b0);
        send_set(16'h8000);
        send_set(16'h8100);
        check_eq("t6_pre_overrun", 32'(overrun), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_reset_outs",
                 {adc_sample_en, m_axis_tvalid, m_axis_tlast, busy, frame_done, overrun,
                  m_axis_tuser, m_axis_tdata}, '0);
        tick();
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        begin_test();
        do_start(16'd1, 8'd0, 4'b0001, 1'b0);
        send_set(16'h9000);
        wait_idle("t6");
        push_set(16'h9000, 4'b0001, 1'b1);
        check_beats("t6");
        check_eq("t6_overrun", 32'(overrun), 32'd0);
        check_eq("t6_frame_done", 32'(fd_cnt - fd_start), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ltc2324_acq_ctrl.md
# ltc2324_acq_ctrl

Acquisition controller that sequences the LTC2324-16 four-channel ADC driver and turns its sample sets into a framed AXI4-Stream for the DMA engine. It gates the driver's sample enable, decimates the 2 Msps sample-set rate, and serializes enabled channels into 16-bit beats. It marks frame boundaries with `tlast` and flags sample sets lost to downstream backpressure.

## Interface
- `FRAME_W`, 16: width of the frame-length configuration (sample sets per frame).
- `DECIM_W`, 8: width of the decimation configuration.

Ports:
- `clk` in 1: system clock, same clock as the ADC driver (110 MHz nominal).
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; latches config and begins acquisition; ignored while `busy`.
- `stop` in 1: one-cycle pulse; ends acquisition at the next frame boundary.
- `cfg_frame_len` in FRAME_W: sample sets per frame; 0 is treated as 1.
- `cfg_decim` in DECIM_W: keep 1 of every `cfg_decim+1` sample sets.
- `cfg_ch_mask` in 4: channel enable, bit0 = ch1; 0 is treated as 4'b0001.
- `cfg_continuous` in 1: 1 = repeat frames until `stop`; 0 = single frame.
- `adc_sample_en` out 1: sample enable to the ADC driver.
- `adc_valid` in 1: driver valid level; high for several cycles per set.
- `adc_ch1`..`adc_ch4` in 16 each: driver channel data, stable while `adc_valid`=1.
- `m_axis_tdata` out 16: sample value.
- `m_axis_tuser` out 2: channel index, 0..3.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tlast` out 1: AXI4-Stream master.
- `busy` out 1: high from `start` accept until the last beat of the final frame is transferred.
- `frame_done` out 1: one-cycle pulse on the transfer of each `tlast` beat.
- `overrun` out 1: sticky; a kept sample set arrived while the serializer was occupied; cleared on `start`.

## Operation
- FSM states:
  - IDLE: `adc_sample_en`=0. On `start`, latch cfg, clear decimation/set counters and `overrun`, go to RUN.
  - RUN: `adc_sample_en`=1.
  - DRAIN: `adc_sample_en`=0; ignore `adc_valid`; go to IDLE when the serializer is empty.
- Set detection: register `adc_valid` once; a set event is `adc_valid`=1 with registered value 0. Each set is counted exactly once regardless of valid length.
- Decimation: `dec_cnt` resets to 0. A set event is kept if `dec_cnt`==0. Every set event updates `dec_cnt` to 0 if it equals `cfg_decim`, else increments it. The first set after `start` is always kept.
- Kept set, serializer empty: snapshot all four channels and the mask, then increment `set_cnt`.
- Kept set, serializer busy: drop the set, set `overrun`, leave `set_cnt` unchanged. A set event and the final beat transfer in the same cycle counts as busy.
- Serializer: emit one beat per enabled channel in ascending index order, advancing on `tvalid & tready`. `tdata`/`tuser` are held stable while stalled.
- `tlast` is set on the final beat of the set that brings `set_cnt` to `cfg_frame_len`. That set also resets `set_cnt` to 0.
- Frame end (the kept set that completes a frame): go to DRAIN if `cfg_continuous`=0 or a stop is pending; otherwise stay in RUN.
- `stop` in RUN sets stop-pending; `stop` in IDLE/DRAIN has no effect.
- Reset: all outputs 0 and state IDLE. Reset mid-frame discards the snapshot without emitting `tlast`.

## Timing
- Set event detected at edge k: snapshot loaded and `m_axis_tvalid`=1 from edge k. The first beat is visible in cycle k+1.
- With `tready`=1, N enabled channels take N consecutive cycles, well inside the 55-cycle set period at 2 Msps.
- On the frame-completing set, `adc_sample_en` falls on the same edge k. The driver completes its current cycle; no further set is accepted.
- `busy` rises on the edge after `start`. It falls on the edge after the final `tlast` transfer.
- `frame_done` is registered and high in the cycle after the `tlast` handshake.

## Structure
- Package `ltc2324_acq_pkg`: FSM state enum, channel index type (2 bits), sample width constant (16), channel count constant (4).
- Sub-module `ltc2324_ch_serializer`: snapshot registers, mask-driven next-channel selection, AXIS beat output, and its `empty` status.

## Test plan
- Mask 4'b1111, decim 0, frame_len 2, one-shot, `tready`=1 → 8 beats, `tuser` 0,1,2,3,0,1,2,3; `tlast` only on beat 8; one `frame_done`; `busy` then falls.
- Mask 4'b0101, decim 2, frame_len 3, one-shot → sets 1, 4, 7 kept; beats `tuser` 0,2 per set; 6 beats total.
- Mask 0 → treated as ch1 only; one beat per kept set.
- `tready`=0 held for 120 cycles in RUN → `overrun`=1; the held set is emitted intact after release; dropped sets are not counted toward the frame.
- Continuous, frame_len 4, `stop` mid-frame 2 → frame 2 completes with `tlast`; `adc_sample_en` falls; 8 sets total.
- `rst_n` low during a beat stall → all outputs 0 immediately; a subsequent `start` gives a clean frame with `overrun`=0.
